// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snake_pkg
// Purpose  : Shared types and constants for the snake move sequencer: travel
//            direction encoding, sequencer FSM states, playfield limits and
//            the direction-reversal helper.
// Revision : 1.0 - initial release
// ============================================================================
package snake_pkg;

  localparam int DIR_W = 2;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_UP    = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_PAUSED = 2'b01,
    ST_DEAD   = 2'b10
  } state_t;

  localparam logic [4:0] GRID_MIN  = 5'd1;
  localparam logic [4:0] GRID_MAX  = 5'd28;
  localparam logic [4:0] BORDER_LO = 5'd0;
  localparam logic [4:0] BORDER_HI = 5'd29;

  // Opposite directions differ only in bit 1 (right<->left, down<->up).
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage : snake_pkg
`default_nettype wire

// File: rtl/snake_dir_fifo.sv
`default_nettype none
// ============================================================================
// Module   : snake_dir_fifo
// Purpose  : QDEPTH x 2-bit FIFO of pending turns. No filtering; the caller
//            only pushes when not full and only pops when not empty.
// Ports    : clk_1, rst (async, active-high)
//            push, push_dir  - write request and data
//            pop             - read request (advances head)
//            head_dir        - oldest entry
//            tail_dir        - newest entry
//            level           - occupied entries (0..QDEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module snake_dir_fifo
  import snake_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic             clk_1,
  input  logic             rst,
  input  logic             push,
  input  logic [DIR_W-1:0] push_dir,
  input  logic             pop,
  output logic [DIR_W-1:0] head_dir,
  output logic [DIR_W-1:0] tail_dir,
  output logic [3:0]       level
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [AW-1:0] c_ptr_one = AW'(1);

  logic [DIR_W-1:0] r_mem [QDEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [3:0]       r_level;
  logic [AW-1:0]    w_tail_ptr;

  // Depth is a power of two, so pointers wrap on natural overflow.
  assign w_tail_ptr = r_wr_ptr - c_ptr_one;
  assign head_dir   = r_mem[r_rd_ptr];
  assign tail_dir   = r_mem[w_tail_ptr];
  assign level      = r_level;

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({push, pop})
        2'b10:   r_level <= r_level + 4'd1;
        2'b01:   r_level <= r_level - 4'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers/level.
  always_ff @(posedge clk_1) begin
    if (push) r_mem[r_wr_ptr] <= push_dir;
  end

endmodule : snake_dir_fifo
`default_nettype wire

// File: rtl/snake_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : snake_move_sequencer
// Purpose  : Accepts direction requests over valid/ready, queues legal turns,
//            and advances the snake head one cell every TICK_DIV cycles.
// Ports    : clk_1, rst (async, active-high)
//            pause               - freezes the step counter while high
//            key_valid, key_dir  - direction request (00 R, 01 D, 10 L, 11 U)
//            key_ready           - request accepted on valid & ready
//            mov_dir             - current travel direction
//            head_x, head_y      - head coordinate
//            step                - one-cycle pulse on each head update
//            hit_wall            - sticky collision flag
//            queue_level         - occupied turn-queue entries
// Config   : SNAKE_WRAP_EN - when defined the playfield wraps (1..28) on both
//            axes and collisions never occur.
// Revision : 1.0 - initial release
// ============================================================================
module snake_move_sequencer
  import snake_pkg::*;
#(
  parameter int         TICK_DIV  = 25,
  parameter int         QDEPTH    = 4,
  parameter logic [4:0] START_X   = 5'd3,
  parameter logic [4:0] START_Y   = 5'd3,
  parameter logic [1:0] START_DIR = 2'b00
) (
  input  logic       clk_1,
  input  logic       rst,
  input  logic       pause,
  input  logic       key_valid,
  input  logic [1:0] key_dir,
  output logic       key_ready,
  output logic [1:0] mov_dir,
  output logic [4:0] head_x,
  output logic [4:0] head_y,
  output logic       step,
  output logic       hit_wall,
  output logic [2:0] queue_level
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] c_tick_last = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] c_tick_one  = CW'(1);
  localparam logic [3:0]    c_qdepth    = 4'(QDEPTH);

  state_t      r_state, w_state_next;
  dir_t        r_mov_dir;
  logic [4:0]  r_head_x, r_head_y;
  logic        r_step, r_hit_wall;
  logic [CW-1:0] r_tick;

  logic [DIR_W-1:0] w_fifo_head, w_fifo_tail;
  logic [3:0]       w_level;
  dir_t             w_ref_dir, w_new_dir;
  logic             w_accept, w_push, w_pop, w_step_evt, w_hit;
  logic [4:0]       w_raw_x, w_raw_y, w_next_x, w_next_y;

  snake_dir_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk_1    (clk_1),
    .rst      (rst),
    .push     (w_push),
    .push_dir (key_dir),
    .pop      (w_pop),
    .head_dir (w_fifo_head),
    .tail_dir (w_fifo_tail),
    .level    (w_level)
  );

  // Ready depends only on registered state (and reset), never on key_valid.
  assign key_ready = !rst && (w_level < c_qdepth) && (r_state != ST_DEAD);
  assign w_accept  = key_valid && key_ready;

  // Filter against the newest pending turn, or the live direction if none.
  assign w_ref_dir = (w_level != 4'd0) ? dir_t'(w_fifo_tail) : r_mov_dir;
  assign w_push    = w_accept && (key_dir != w_ref_dir)
                     && (key_dir != opposite(w_ref_dir));

  assign w_step_evt = (r_state == ST_RUN) && (r_tick == c_tick_last);
  assign w_pop      = w_step_evt && (w_level != 4'd0);
  assign w_new_dir  = w_pop ? dir_t'(w_fifo_head) : r_mov_dir;

  always_comb begin
    w_raw_x = r_head_x;
    w_raw_y = r_head_y;
    case (w_new_dir)
      DIR_RIGHT: w_raw_x = r_head_x + 5'd1;
      DIR_DOWN:  w_raw_y = r_head_y + 5'd1;
      DIR_LEFT:  w_raw_x = r_head_x - 5'd1;
      DIR_UP:    w_raw_y = r_head_y - 5'd1;
      default:   w_raw_x = r_head_x;
    endcase
  end

`ifdef SNAKE_WRAP_EN
  always_comb begin
    w_next_x = w_raw_x;
    w_next_y = w_raw_y;
    if (w_raw_x == BORDER_HI) w_next_x = GRID_MIN;
    if (w_raw_x == BORDER_LO) w_next_x = GRID_MAX;
    if (w_raw_y == BORDER_HI) w_next_y = GRID_MIN;
    if (w_raw_y == BORDER_LO) w_next_y = GRID_MAX;
  end
  assign w_hit = 1'b0;
`else
  // The border cell is committed to the head so the crash position is visible.
  assign w_next_x = w_raw_x;
  assign w_next_y = w_raw_y;
  assign w_hit    = (w_raw_x == BORDER_LO) || (w_raw_x == BORDER_HI) ||
                    (w_raw_y == BORDER_LO) || (w_raw_y == BORDER_HI);
`endif

  // FSM state register
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_next;
  end

  // FSM next-state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_step_evt && w_hit) w_state_next = ST_DEAD;
        else if (pause)          w_state_next = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (!pause) w_state_next = ST_RUN;
      end
      ST_DEAD:  w_state_next = ST_DEAD;
      default:  w_state_next = ST_RUN;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      r_mov_dir  <= dir_t'(START_DIR);
      r_head_x   <= START_X;
      r_head_y   <= START_Y;
      r_step     <= 1'b0;
      r_hit_wall <= 1'b0;
      r_tick     <= '0;
    end else begin
      r_step <= w_step_evt;
      if (r_state == ST_RUN) begin
        r_tick <= (r_tick == c_tick_last) ? '0 : r_tick + c_tick_one;
      end
      if (w_step_evt) begin
        r_mov_dir <= w_new_dir;
        r_head_x  <= w_next_x;
        r_head_y  <= w_next_y;
        if (w_hit) r_hit_wall <= 1'b1;
      end
    end
  end

  assign mov_dir     = r_mov_dir;
  assign head_x      = r_head_x;
  assign head_y      = r_head_y;
  assign step        = r_step;
  assign hit_wall    = r_hit_wall;
  assign queue_level = (w_level > 4'd7) ? 3'd7 : w_level[2:0];

endmodule : snake_move_sequencer
`default_nettype wire

// File: tb/tb_snake_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_move_sequencer
// Purpose  : Self-checking bench for snake_move_sequencer. A queue-based
//            game model predicts every output each cycle; directed scenarios
//            are followed by a randomized run with pauses and resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_move_sequencer;

  localparam int TICK_DIV = 25;
  localparam int QDEPTH   = 4;

  logic       clk_1 = 1'b0;
  logic       rst   = 1'b0;
  logic       pause = 1'b0;
  logic       key_valid = 1'b0;
  logic [1:0] key_dir = 2'b00;
  logic       key_ready;
  logic [1:0] mov_dir;
  logic [4:0] head_x, head_y;
  logic       step, hit_wall;
  logic [2:0] queue_level;

  int n_checks = 0;
  int n_pass   = 0;

  snake_move_sequencer #(
    .TICK_DIV (TICK_DIV),
    .QDEPTH   (QDEPTH),
    .START_X  (5'd3),
    .START_Y  (5'd3),
    .START_DIR(2'b00)
  ) dut (
    .clk_1      (clk_1),
    .rst        (rst),
    .pause      (pause),
    .key_valid  (key_valid),
    .key_dir    (key_dir),
    .key_ready  (key_ready),
    .mov_dir    (mov_dir),
    .head_x     (head_x),
    .head_y     (head_y),
    .step       (step),
    .hit_wall   (hit_wall),
    .queue_level(queue_level)
  );

  always #5 clk_1 = ~clk_1;

  // ---------------- reference model ----------------
  int         m_x, m_y, m_cnt;
  logic [1:0] m_dir;
  logic [1:0] m_q[$];
  bit         m_dead, m_paused, m_step;

  function automatic void m_reset();
    m_x = 3; m_y = 3; m_dir = 2'b00; m_cnt = 0;
    m_q.delete();
    m_dead = 0; m_paused = 0; m_step = 0;
  endfunction

  function automatic bit m_ready();
    return (m_q.size() < QDEPTH) && !m_dead;
  endfunction

  // One game clock: handshake, possible step, then mode change.
  function automatic void m_clock(input bit v, input logic [1:0] d, input bit p);
    bit         acc, push, evt, hit;
    logic [1:0] rd;
    int         nx, ny, pre;
    acc  = v && m_ready();
    push = 0;
    if (acc) begin
      rd   = (m_q.size() > 0) ? m_q[$] : m_dir;
      push = (d != rd) && (d != (rd ^ 2'b10));
    end
    pre = m_q.size();
    evt = !m_dead && !m_paused && (m_cnt == TICK_DIV - 1);
    hit = 0;
    if (evt) begin
      if (pre > 0) m_dir = m_q.pop_front();
      nx = m_x; ny = m_y;
      case (m_dir)
        2'd0: nx = (m_x + 1) % 32;
        2'd1: ny = (m_y + 1) % 32;
        2'd2: nx = (m_x + 31) % 32;
        default: ny = (m_y + 31) % 32;
      endcase
`ifdef SNAKE_WRAP_EN
      if (nx == 29) nx = 1;
      if (nx == 0)  nx = 28;
      if (ny == 29) ny = 1;
      if (ny == 0)  ny = 28;
`else
      hit = (nx == 0) || (nx == 29) || (ny == 0) || (ny == 29);
`endif
      m_x = nx; m_y = ny;
    end
    if (push) m_q.push_back(d);
    if (!m_dead && !m_paused) m_cnt = (m_cnt + 1) % TICK_DIV;
    if (evt && hit)              m_dead = 1;
    else if (!m_dead && !m_paused && p) m_paused = 1;
    else if (m_paused && !p)     m_paused = 0;
    m_step = evt;
  endfunction

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_outputs();
    check_eq("head_x",      head_x,      m_x);
    check_eq("head_y",      head_y,      m_y);
    check_eq("mov_dir",     mov_dir,     m_dir);
    check_eq("step",        step,        m_step);
    check_eq("hit_wall",    hit_wall,    m_dead);
    check_eq("queue_level", queue_level, m_q.size());
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic cycle(input bit v, input logic [1:0] d, input bit p, output bit acc);
    key_valid = v; key_dir = d; pause = p;
    #1;
    check_eq("key_ready", key_ready, m_ready());
    acc = v && m_ready();
    @(posedge clk_1);
    m_clock(v, d, p);
    #1;
    check_outputs();
    @(negedge clk_1);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(0, 2'($urandom), 0, a);
  endtask

  task automatic do_reset();
    bit a;
    rst = 1; key_valid = 0; pause = 0;
    #1;
    m_reset();
    check_eq("rst_key_ready", key_ready, 0);
    check_outputs();
    @(negedge clk_1);
    check_outputs();
    rst = 0;
    a = 0;
  endtask

  task automatic send_key(input logic [1:0] d);
    bit a, done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      cycle(1, d, 0, a);
      done = a;
    end
    key_valid = 0;
    if (!done) check_eq("send_key_timeout", 0, 1);
  endtask

  task automatic wait_step();
    bit a, seen;
    seen = 0;
    for (int i = 0; i < 4 * TICK_DIV && !seen; i++) begin
      cycle(0, 2'b00, 0, a);
      seen = m_step;
    end
    if (!seen) check_eq("wait_step_timeout", 0, 1);
  endtask

  logic [1:0] turn;
  int         pause_left;

  initial begin
    bit a;
    m_reset();
    @(negedge clk_1);
    do_reset();

    // Idle run to the right: three steps.
    idle(3 * TICK_DIV);
    check_eq("idle_x", head_x, 6);
    check_eq("idle_y", head_y, 3);

    // Reversal and duplicate requests are dropped.
    send_key(2'b10);
    check_eq("drop_rev_level", queue_level, 0);
    send_key(2'b00);
    check_eq("drop_dup_level", queue_level, 0);

    // Down then left queued, applied on the following steps.
    send_key(2'b01);
    send_key(2'b10);
    check_eq("two_turns_level", queue_level, 2);
    wait_step();
    check_eq("turn1_dir", mov_dir, 2'b01);
    wait_step();
    check_eq("turn2_dir", mov_dir, 2'b10);

    // Fill the queue just after a step, then hold a fifth request.
    for (int i = 0; i < QDEPTH; i++) begin
      turn = ((m_q.size() > 0) ? m_q[$] : m_dir) ^ 2'b01;
      send_key(turn);
    end
    check_eq("full_level", queue_level, QDEPTH);
    check_eq("full_ready", key_ready, 0);
    turn = m_q[$] ^ 2'b01;
    send_key(turn);
    check_eq("fifth_level", queue_level, QDEPTH);
    idle(6 * TICK_DIV);

    // Pause mid-count, with a request made during the pause.
    do_reset();
    idle(10);
    for (int i = 0; i < 10; i++) begin
      cycle((i == 4), 2'b01, 1, a);
      if (i == 4) check_eq("pause_accept", a, 1);
    end
    idle(2 * TICK_DIV);
    check_eq("pause_turn_dir", mov_dir, 2'b01);

    // Randomized run with pauses and occasional resets.
    do_reset();
    pause_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      if (pause_left > 0) pause_left--;
      else if ($urandom_range(0, 59) == 0) pause_left = $urandom_range(1, 12);
      cycle(($urandom_range(0, 3) == 0), 2'($urandom), (pause_left > 0), a);
    end

    // Head straight right into the east border.
    do_reset();
    idle(26 * TICK_DIV);
`ifdef SNAKE_WRAP_EN
    check_eq("edge_x", head_x, 1);
    check_eq("edge_hit", hit_wall, 0);
`else
    check_eq("edge_x", head_x, 29);
    check_eq("edge_hit", hit_wall, 1);
    check_eq("dead_ready", key_ready, 0);
`endif
    idle(4 * TICK_DIV);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_snake_move_sequencer
`default_nettype wire
